// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, and late
// multi-cycle-unit results queue in a small FIFO until the port is free.
module wb_port_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Reg_Write_W,
  input  logic [4:0]  Rd_W,
  input  logic [31:0] Result_W,
  input  logic        MC_Valid,
  input  logic [4:0]  MC_Rd,
  input  logic [31:0] MC_Data,
  output logic        MC_Ready,
  output logic        RF_Write_En,
  output logic [4:0]  RF_Rd,
  output logic [31:0] RF_Data,
  input  logic [4:0]  Rs1_D,
  input  logic [4:0]  Rs2_D,
  output logic        Hazard_D,
  output logic        Stall_Req,
  output logic        Pending
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [FIFO_DEPTH-1:0] r_vld;
  logic [4:0]            r_rd   [FIFO_DEPTH];
  logic [31:0]           r_data [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [WW-1:0]         r_wait;
  logic                  r_stall;

  logic [FIFO_DEPTH-1:0] w_vld_next;
  logic [FIFO_DEPTH-1:0] w_squash;
  logic [FIFO_DEPTH-1:0] w_match;
  logic                  w_pipe_req;
  logic                  w_nonempty;
  logic                  w_head_vld;
  logic                  w_head_squash;
  logic                  w_deq;
  logic                  w_enq;
  logic [CW-1:0]         w_count_next;
  logic [WW-1:0]         w_wait_next;
  logic                  w_stall_next;

  assign w_pipe_req    = Reg_Write_W && (Rd_W != 5'd0);
  assign w_nonempty    = (r_count != '0);
  assign w_head_vld    = w_nonempty && r_vld[r_rptr];
  assign w_head_squash = w_squash[r_rptr];
  // Any occupied head (valid or squashed) leaves whenever the pipeline is silent.
  assign w_deq         = w_nonempty && !w_pipe_req;
  assign MC_Ready      = (r_count < CW'(FIFO_DEPTH));
  assign w_enq         = MC_Valid && MC_Ready && (MC_Rd != 5'd0);

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      assign w_squash[gi] = w_pipe_req && r_vld[gi] && (r_rd[gi] == Rd_W);
      assign w_match[gi]  = r_vld[gi] &&
                            (((Rs1_D != 5'd0) && (r_rd[gi] == Rs1_D)) ||
                             ((Rs2_D != 5'd0) && (r_rd[gi] == Rs2_D)));
      // A fresh enqueue wins over a squash of the same register this cycle.
      assign w_vld_next[gi] = (w_enq && (r_wptr == AW'(gi))) ? 1'b1 :
                              (w_deq && (r_rptr == AW'(gi))) ? 1'b0 :
                              w_squash[gi]                   ? 1'b0 :
                                                               r_vld[gi];
    end
  endgenerate

  assign Hazard_D  = |w_match;
  assign Pending   = |r_vld;
  assign Stall_Req = r_stall;

  always_comb begin
    RF_Write_En = 1'b0;
    RF_Rd       = 5'd0;
    RF_Data     = 32'd0;
    if (w_pipe_req) begin
      RF_Write_En = 1'b1;
      RF_Rd       = Rd_W;
      RF_Data     = Result_W;
    end else if (w_head_vld) begin
      RF_Write_En = 1'b1;
      RF_Rd       = r_rd[r_rptr];
      RF_Data     = r_data[r_rptr];
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_enq && !w_deq)
      w_count_next = r_count + 1'b1;
    else if (!w_enq && w_deq)
      w_count_next = r_count - 1'b1;

    w_wait_next = '0;
    if (w_head_vld && w_pipe_req && !w_head_squash)
      w_wait_next = (r_wait == WW'(MAX_WAIT)) ? r_wait : r_wait + 1'b1;

    w_stall_next = r_stall;
    if (w_vld_next == '0)
      w_stall_next = 1'b0;
    else if (w_wait_next == WW'(MAX_WAIT))
      w_stall_next = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vld   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wait  <= '0;
      r_stall <= 1'b0;
    end else begin
      r_vld   <= w_vld_next;
      r_count <= w_count_next;
      r_wait  <= w_wait_next;
      r_stall <= w_stall_next;
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Payload storage needs no reset; the valid bits qualify every read.
  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_rd[r_wptr]   <= MC_Rd;
      r_data[r_wptr] <= MC_Data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected RF writes go into a scoreboard
// queue, and a negedge monitor checks every write the port actually makes.
module tb_wb_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Reg_Write_W;
  logic [4:0]  Rd_W;
  logic [31:0] Result_W;
  logic        MC_Valid;
  logic [4:0]  MC_Rd;
  logic [31:0] MC_Data;
  logic        MC_Ready;
  logic        RF_Write_En;
  logic [4:0]  RF_Rd;
  logic [31:0] RF_Data;
  logic [4:0]  Rs1_D;
  logic [4:0]  Rs2_D;
  logic        Hazard_D;
  logic        Stall_Req;
  logic        Pending;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;

  wb_port_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .Reg_Write_W(Reg_Write_W), .Rd_W(Rd_W), .Result_W(Result_W),
    .MC_Valid(MC_Valid), .MC_Rd(MC_Rd), .MC_Data(MC_Data), .MC_Ready(MC_Ready),
    .RF_Write_En(RF_Write_En), .RF_Rd(RF_Rd), .RF_Data(RF_Data),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Hazard_D(Hazard_D),
    .Stall_Req(Stall_Req), .Pending(Pending)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
    Reg_Write_W = we;
    Rd_W        = rd;
    Result_W    = d;
  endtask

  task automatic mcu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    MC_Valid = v;
    MC_Rd    = rd;
    MC_Data  = d;
  endtask

  // Monitor: every RF write must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (RF_Write_En === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rf_unexpected: got x%0d=%h, expected no write", RF_Rd, RF_Data);
      end else begin
        mon_e = exp_q.pop_front();
        if (RF_Rd !== mon_e.rd || RF_Data !== mon_e.data) begin
          n_fail++;
          $display("FAIL rf_write: got x%0d=%h, expected x%0d=%h",
                   RF_Rd, RF_Data, mon_e.rd, mon_e.data);
        end else begin
          $display("[MON] t=%0t rf write x%0d=%h ok", $time, RF_Rd, RF_Data);
        end
      end
    end
  end

  initial begin
    RST_N = 1'b1;
    pipe(1'b0, 5'd0, 32'd0);
    mcu(1'b0, 5'd0, 32'd0);
    Rs1_D = 5'd0;
    Rs2_D = 5'd0;
    #2 RST_N = 1'b0;

    // Reset state
    neg();
    chk("rst_mc_ready", MC_Ready, 1);
    chk("rst_pending", Pending, 0);
    chk("rst_stall", Stall_Req, 0);
    chk("rst_hazard", Hazard_D, 0);
    chk("rst_rf_we", RF_Write_En, 0);
    cyc();
    RST_N = 1'b1;

    // Idle port: MCU result reaches the RF one cycle after acceptance
    push(5'd5, 32'hDEADBEEF);
    cyc();
    mcu(1'b1, 5'd5, 32'hDEADBEEF);
    neg();
    chk("idle_no_bypass", RF_Write_En, 0);
    cyc();
    mcu(1'b0, 5'd0, 32'd0);
    neg();
    chk("idle_pending_q", Pending, 1);
    cyc();
    neg();
    chk("idle_pending_after", Pending, 0);
    chk("idle_rf_rd", RF_Rd, 0);

    // Contention: four denials raise Stall_Req, then x7 drains
    for (int k = 0; k < 4; k++) push(5'(3 + k), 32'h44444444);
    push(5'd7, 32'h11111111);
    cyc();
    mcu(1'b1, 5'd7, 32'h11111111);
    for (int k = 0; k < 4; k++) begin
      cyc();
      mcu(1'b0, 5'd0, 32'd0);
      pipe(1'b1, 5'(3 + k), 32'h44444444);
      neg();
      chk("cont_stall_early", Stall_Req, 0);
    end
    cyc();
    pipe(1'b0, 5'd0, 32'd0);
    neg();
    chk("cont_stall_set", Stall_Req, 1);
    cyc();
    neg();
    chk("cont_stall_clear", Stall_Req, 0);
    chk("cont_pending", Pending, 0);

    // Full FIFO: third MCU result held off until the first dequeue
    push(5'd1, 32'h00000001);
    push(5'd2, 32'h00000002);
    push(5'd1, 32'h00000003);
    push(5'd8, 32'h88888888);
    push(5'd9, 32'h99999999);
    push(5'd13, 32'hDDDDDDDD);
    cyc();
    mcu(1'b1, 5'd8, 32'h88888888);
    pipe(1'b1, 5'd1, 32'h00000001);
    cyc();
    mcu(1'b1, 5'd9, 32'h99999999);
    pipe(1'b1, 5'd2, 32'h00000002);
    cyc();
    mcu(1'b1, 5'd13, 32'hDDDDDDDD);
    pipe(1'b1, 5'd1, 32'h00000003);
    neg();
    chk("full_ready_lo", MC_Ready, 0);
    chk("full_pending", Pending, 1);
    cyc();
    pipe(1'b0, 5'd0, 32'd0);
    neg();
    chk("full_ready_hold", MC_Ready, 0);
    cyc();
    neg();
    chk("full_ready_back", MC_Ready, 1);
    cyc();
    mcu(1'b0, 5'd0, 32'd0);
    cyc();
    neg();
    chk("full_pending_after", Pending, 0);

    // WAW squash: queued x10 superseded by the pipeline write
    push(5'd10, 32'hFFFFFFFF);
    cyc();
    mcu(1'b1, 5'd10, 32'hAAAAAAAA);
    cyc();
    mcu(1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd10, 32'hFFFFFFFF);
    cyc();
    pipe(1'b0, 5'd0, 32'd0);
    Rs1_D = 5'd10;
    neg();
    chk("waw_skip_no_write", RF_Write_En, 0);
    chk("waw_skip_hazard", Hazard_D, 0);
    cyc();
    Rs1_D = 5'd0;
    neg();
    chk("waw_pending_after", Pending, 0);
    chk("waw_ready", MC_Ready, 1);

    // Hazards and x0 handling
    push(5'd1, 32'h00000021);
    push(5'd12, 32'h0C0C0C0C);
    cyc();
    mcu(1'b1, 5'd12, 32'h0C0C0C0C);
    cyc();
    mcu(1'b1, 5'd0, 32'h55555555);
    pipe(1'b1, 5'd1, 32'h00000021);
    Rs1_D = 5'd12;
    Rs2_D = 5'd0;
    neg();
    chk("haz_rs1_hit", Hazard_D, 1);
    cyc();
    mcu(1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd0, 32'h00000099);
    Rs1_D = 5'd3;
    neg();
    chk("haz_rs2_zero", Hazard_D, 0);
    chk("x0_head_drains", RF_Rd, 12);
    cyc();
    neg();
    chk("x0_no_write", RF_Write_En, 0);
    chk("x0_dropped", Pending, 0);
    cyc();
    pipe(1'b0, 5'd0, 32'd0);
    Rs1_D = 5'd0;

    // Reset mid-operation discards queued results
    push(5'd1, 32'h00000031);
    push(5'd2, 32'h00000032);
    cyc();
    mcu(1'b1, 5'd14, 32'hEEEEEEEE);
    pipe(1'b1, 5'd1, 32'h00000031);
    cyc();
    mcu(1'b1, 5'd15, 32'hF0F0F0F0);
    pipe(1'b1, 5'd2, 32'h00000032);
    cyc();
    mcu(1'b0, 5'd0, 32'd0);
    pipe(1'b0, 5'd0, 32'd0);
    RST_N = 1'b0;
    neg();
    chk("mid_rst_pending", Pending, 0);
    chk("mid_rst_ready", MC_Ready, 1);
    chk("mid_rst_stall", Stall_Req, 0);
    chk("mid_rst_rf_we", RF_Write_En, 0);
    cyc();
    RST_N = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      neg();
      chk("post_rst_idle", RF_Write_En, 0);
    end

    cyc();
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between the in-order pipeline writeback result and a late-returning multi-cycle unit (MCU) result stream, e.g. an iterative divider.
- Pipeline writeback always has priority; MCU results wait in a small FIFO until the port is free.
- A wait counter requests a pipeline stall when an MCU result is starved.
- Decode-stage read-after-write hazards against queued MCU destinations are flagged.

Parameters:
FIFO_DEPTH, 2, number of buffered MCU results (power of two, >=2)
MAX_WAIT, 4, consecutive denied cycles of the FIFO head before Stall_Req asserts (>=1)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
Reg_Write_W  in  1  pipeline writeback write enable
Rd_W  in  5  pipeline destination register
Result_W  in  32  pipeline writeback value (output of the writeback mux)
MC_Valid  in  1  MCU result valid
MC_Rd  in  5  MCU destination register
MC_Data  in  32  MCU result value
MC_Ready  out  1  FIFO can accept an MCU result
RF_Write_En  out  1  register file write enable
RF_Rd  out  5  register file write address
RF_Data  out  32  register file write data
Rs1_D  in  5  decode-stage source register 1
Rs2_D  in  5  decode-stage source register 2
Hazard_D  out  1  a decode source matches a queued MCU destination
Stall_Req  out  1  request to freeze the pipeline and drain the FIFO
Pending  out  1  FIFO non-empty

Behaviour:
- Reset (RST_N low, asynchronous):
  - FIFO emptied (all entry valid bits 0), pointers 0, count 0, wait counter 0, Stall_Req 0.
  - Outputs therefore read MC_Ready=1, Pending=0, Hazard_D=0.
  - RF_* carry the pipeline request only.
  - Reset mid-operation discards all queued MCU results.
- Pipeline write request: Reg_Write_W=1 and Rd_W!=0.
  - Rd_W=0 is never requested and never occupies the port.
- Port mux (combinational, same cycle):
  - If a pipeline request exists: RF_Write_En=1, RF_Rd=Rd_W, RF_Data=Result_W.
  - Else if the FIFO head is valid: RF_Write_En=1, RF_Rd=head Rd, RF_Data=head data; the head dequeues at the clock edge.
  - Else RF_Write_En=0; RF_Rd and RF_Data are 0.
- Enqueue:
  - MC_Ready = (count < FIFO_DEPTH), computed from registered count only. There is no same-cycle bypass to the port.
  - Minimum MCU-to-RF latency is 1 cycle after acceptance.
  - MC_Valid && MC_Ready with MC_Rd!=0 enqueues at the edge. MC_Rd=0 is accepted and dropped.
  - MCU holds MC_Rd and MC_Data stable while MC_Valid && !MC_Ready.
- Simultaneous enqueue and dequeue on a full FIFO is not possible, because MC_Ready is 0 when full.
  - On a non-full FIFO, both occur in one cycle and count is unchanged.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. Full/empty are taken from count.
- WAW squash:
  - When a pipeline request writes Rd_W, every queued valid entry with the same Rd is invalidated at that edge.
  - The pipeline write is the younger value.
  - Invalid entries at the head are skipped: they dequeue without a write, one per cycle, while the port is idle.
  - An entry enqueued in the same cycle is not squashed.
- Hazard_D = 1 when Rs1_D!=0 or Rs2_D!=0 matches the Rd of any valid queued entry. Combinational.
- Pending = any valid entry present.
- Wait counter:
  - Increments each cycle the head is valid and denied by a pipeline request; saturates at MAX_WAIT.
  - Clears when the head dequeues or is squashed.
- Stall_Req is registered:
  - Set on the edge where the wait counter reaches MAX_WAIT.
  - Cleared on the edge the FIFO becomes empty of valid entries.
  - While Stall_Req=1, the pipeline drives Reg_Write_W=0. The bench must honour this.

Test Plan:
- Reset mid-operation: queue 2 MCU entries, pulse RST_N low -> Pending=0, MC_Ready=1, Stall_Req=0 immediately; no RF write from the discarded entries.
- Idle port: MC_Valid=1, MC_Rd=5, MC_Data=0xDEADBEEF, Reg_Write_W=0 -> next cycle RF_Write_En=1, RF_Rd=5, RF_Data=0xDEADBEEF; Pending=0 after.
- Contention: MCU queues x7=0x11111111 while the pipeline writes x3,x4,x5,x6 back-to-back with Result_W=0x44444444 -> RF shows pipeline values for 4 cycles; Stall_Req=1 after the 4th denial; Reg_Write_W=0 -> x7=0x11111111 written; Stall_Req=0 next edge.
- Full FIFO: enqueue x8 and x9 with the pipeline writing continuously -> MC_Ready=0; a third MC_Valid is held off until the first dequeue; order preserved (x8 then x9).
- WAW squash: queue x10=0xAAAAAAAA, then pipeline writes x10=0xFFFFFFFF -> the queued entry is never written; Pending falls after the skip cycle.
- Hazards and x0: with x12 queued, Rs1_D=12 -> Hazard_D=1; Rs2_D=0 with queued MC_Rd=0 -> nothing enqueued, Hazard_D=0; Reg_Write_W=1, Rd_W=0 -> RF_Write_En=0 and the head drains.
